// File: rtl/cpu_pkg.sv
// Shared definitions for the 24-bit datapath: instruction width, NOP word,
// fetch-stage state encoding and the opcode field position used by decode.
package cpu_pkg;

  localparam int INSTR_W = 24;
  localparam logic [INSTR_W-1:0] NOP = 24'h000000;

  // Opcode field occupies the two top bits of every instruction word.
  localparam int OPC_MSB = 23;
  localparam int OPC_LSB = 22;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    FLUSH
  } fetch_state_e;

  function automatic logic [OPC_MSB-OPC_LSB:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_skid_reg.sv
// One-entry skid register: parks a fetched {instruction, pc} pair while the
// decode stage is stalled, so an already-returned memory word is never lost.
module fetch_skid_reg
  import cpu_pkg::*;
#(
  parameter int W = INSTR_W + 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         unload,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid
);

  // Entry storage; clear (redirect) beats load, load beats unload.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the data field is reset too even though valid alone qualifies it;
    // it is a single register, and a known value keeps traces readable.
    if (reset) begin
      dout  <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      dout  <= din;
      valid <= 1'b1;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the req/ready handshake with
// instruction memory, presents registered code/code_valid/code_pc to decode,
// absorbs stalls with a one-entry skid and handles taken-branch redirects,
// including redirects that land while a memory request is outstanding.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               imem_ready,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [INSTR_W-1:0] code,
  output logic               code_valid,
  output logic [ADDR_W-1:0]  code_pc
);

  fetch_state_e state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
  logic [INSTR_W-1:0] code_d;
  logic [ADDR_W-1:0]  code_pc_d;
  logic               code_valid_d;
  logic               started_q;

  logic                      skid_load, skid_unload, skid_clear;
  logic [INSTR_W+ADDR_W-1:0] skid_dout;
  logic                      skid_valid;

  logic fire;
  logic slot_free;

  // Request is decoded from registered state only; started_q holds it low
  // for the first cycle after reset so the bus starts cleanly.
  assign imem_req  = started_q && (state_q != HOLD);
  assign imem_addr = req_addr_q;
  assign fire      = imem_req && imem_ready;
  assign slot_free = !code_valid || !stall;

  fetch_skid_reg #(
    .W(INSTR_W + ADDR_W)
  ) u_skid (
    .clk    (clk),
    .reset  (reset),
    .load   (skid_load),
    .unload (skid_unload),
    .clear  (skid_clear),
    .din    ({imem_data, req_addr_q}),
    .dout   (skid_dout),
    .valid  (skid_valid)
  );

  // Next-state and datapath decode; redirect outranks memory return and stall.
  always_comb begin
    // NOTE: every signal assigned below gets its hold value first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    code_d       = code;
    code_pc_d    = code_pc;
    code_valid_d = code_valid;
    skid_load    = 1'b0;
    skid_unload  = 1'b0;
    skid_clear   = 1'b0;

    if (branch_taken) begin
      pc_d         = branch_target;
      code_valid_d = 1'b0;
      skid_clear   = 1'b1;
      unique case (state_q)
        FETCH: begin
          if (imem_req && !imem_ready) begin
            // Request in flight: keep it on the bus and drop its data later.
            state_d = FLUSH;
          end else begin
            req_addr_d = branch_target;
            state_d    = FETCH;
          end
        end
        HOLD: begin
          req_addr_d = branch_target;
          state_d    = FETCH;
        end
        default: state_d = FLUSH;
      endcase
    end else begin
      unique case (state_q)
        FETCH: begin
          if (fire) begin
            if (slot_free) begin
              code_d       = imem_data;
              code_pc_d    = req_addr_q;
              code_valid_d = 1'b1;
            end else begin
              skid_load = 1'b1;
              state_d   = HOLD;
            end
            pc_d       = req_addr_q + ADDR_W'(1);
            req_addr_d = req_addr_q + ADDR_W'(1);
          end else if (code_valid && !stall) begin
            code_valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            code_d       = skid_dout[ADDR_W +: INSTR_W];
            code_pc_d    = skid_dout[ADDR_W-1:0];
            code_valid_d = skid_valid;
            skid_unload  = 1'b1;
            state_d      = FETCH;
          end
        end
        default: begin
          // FLUSH: pc already holds the redirect target.
          if (fire) begin
            req_addr_d = pc_q;
            state_d    = FETCH;
          end
        end
      endcase
    end
  end

  // State, PC and registered output slot.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      code       <= NOP;
      code_valid <= 1'b0;
      code_pc    <= '0;
      started_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      code       <= code_d;
      code_valid <= code_valid_d;
      code_pc    <= code_pc_d;
      started_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: table of per-cycle vectors for
// streaming/stall/redirect, hand sequences for slow memory, async reset and
// PC wrap on a 4-bit-address instance.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [23:0] imem_data;
  logic        imem_ready = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_target = 8'h00;
  logic [23:0] code;
  logic        code_valid;
  logic [7:0]  code_pc;

  logic        w_reset = 1'b1;
  logic        w_req;
  logic [3:0]  w_addr;
  logic [23:0] w_data;
  logic        w_ready;
  logic [23:0] w_code;
  logic        w_valid;
  logic [3:0]  w_pc;

  int errors = 0;
  int checks = 0;
  int lat = 1;
  int cnt = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_data(imem_data), .imem_ready(imem_ready), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .code(code), .code_valid(code_valid), .code_pc(code_pc)
  );

  instr_fetch_unit #(.ADDR_W(4), .RESET_PC(4'h0)) dut_w (
    .clk(clk), .reset(w_reset), .imem_req(w_req), .imem_addr(w_addr),
    .imem_data(w_data), .imem_ready(w_ready), .stall(1'b0),
    .branch_taken(1'b0), .branch_target(4'h0),
    .code(w_code), .code_valid(w_valid), .code_pc(w_pc)
  );

  // Memory contents: mem[a] = 24'h100000 + a.
  assign imem_data = 24'h100000 + {16'h0000, imem_addr};
  assign w_data    = 24'h100000 + {20'h00000, w_addr};
  assign w_ready   = w_req;

  // Memory with 'lat' cycles of latency, ready pulses on the last cycle.
  always @(negedge clk) begin
    if (reset) begin
      cnt = 0;
      imem_ready = 1'b0;
    end else if (imem_req) begin
      if (cnt >= lat - 1) begin
        imem_ready = 1'b1;
        cnt = 0;
      end else begin
        imem_ready = 1'b0;
        cnt++;
      end
    end else begin
      imem_ready = 1'b0;
      cnt = 0;
    end
  end

  typedef struct {
    logic        stall;
    logic        br;
    logic [7:0]  tgt;
    logic        e_valid;
    logic [23:0] e_code;
    logic [7:0]  e_pc;
    logic        e_req;
    logic [7:0]  e_addr;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   imem_req, 0);
    check({tag, "_valid"}, code_valid, 0);
    check({tag, "_code"},  code, 0);
    check({tag, "_pc"},    code_pc, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //          stall br tgt    valid code        pc     req addr
    vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b1, 24'h100000, 8'h00, 1'b1, 8'h01};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 24'h100001, 8'h01, 1'b1, 8'h02};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 24'h100002, 8'h02, 1'b1, 8'h03};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 24'h100003, 8'h03, 1'b1, 8'h04};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 24'h100004, 8'h04, 1'b1, 8'h05};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 24'h100005, 8'h05, 1'b1, 8'h06};
    // Stall 3 cycles with word 5 on code; word 6 returns into the skid.
    vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 24'h100005, 8'h05, 1'b0, 8'h00};
    vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 24'h100005, 8'h05, 1'b0, 8'h00};
    vecs[8]  = '{1'b1, 1'b0, 8'h00, 1'b1, 24'h100005, 8'h05, 1'b0, 8'h00};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 24'h100006, 8'h06, 1'b1, 8'h07};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 24'h100007, 8'h07, 1'b1, 8'h08};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 24'h100008, 8'h08, 1'b1, 8'h09};
    // Redirect to 0x40 with ready in the same cycle.
    vecs[12] = '{1'b0, 1'b1, 8'h40, 1'b0, 24'h000000, 8'h00, 1'b1, 8'h40};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 24'h100040, 8'h40, 1'b1, 8'h41};
    vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 24'h100041, 8'h41, 1'b1, 8'h42};
    // Stall into HOLD, then redirect from HOLD: skidded word 0x42 is dropped.
    vecs[15] = '{1'b1, 1'b0, 8'h00, 1'b1, 24'h100041, 8'h41, 1'b0, 8'h00};
    vecs[16] = '{1'b1, 1'b1, 8'h80, 1'b0, 24'h000000, 8'h00, 1'b1, 8'h80};
    vecs[17] = '{1'b0, 1'b0, 8'h00, 1'b1, 24'h100080, 8'h80, 1'b1, 8'h81};
    vecs[18] = '{1'b0, 1'b0, 8'h00, 1'b1, 24'h100081, 8'h81, 1'b1, 8'h82};

    // Reset state.
    step();
    step();
    check_reset_outputs("reset");
    reset = 1'b0;
    step();
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, 8'h00);
    check("first_valid", code_valid, 0);

    for (int i = 0; i < 19; i++) begin
      stall = vecs[i].stall;
      branch_taken = vecs[i].br;
      branch_target = vecs[i].tgt;
      step();
      check($sformatf("v%0d_valid", i), code_valid, vecs[i].e_valid);
      check($sformatf("v%0d_req", i), imem_req, vecs[i].e_req);
      if (vecs[i].e_valid) begin
        check($sformatf("v%0d_code", i), code, vecs[i].e_code);
        check($sformatf("v%0d_pc", i), code_pc, vecs[i].e_pc);
      end
      if (vecs[i].e_req)
        check($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
    end
    branch_taken = 1'b0;

    // Async reset in the middle of HOLD.
    stall = 1'b1;
    step();
    check("hold_req", imem_req, 0);
    check("hold_code", code, 24'h100081);
    #2 reset = 1'b1;
    #1 check_reset_outputs("rst_hold");
    stall = 1'b0;
    lat = 3;
    step();
    reset = 1'b0;

    // Slow memory (3 cycles); redirect to 0x20 while the request is in flight.
    step();
    check("slow_req", imem_req, 1);
    check("slow_addr_a", imem_addr, 8'h00);
    step();
    check("slow_addr_b", imem_addr, 8'h00);
    check("slow_valid_b", code_valid, 0);
    branch_taken = 1'b1;
    branch_target = 8'h20;
    step();
    branch_taken = 1'b0;
    check("flush_req", imem_req, 1);
    check("flush_addr_held", imem_addr, 8'h00);
    check("flush_valid", code_valid, 0);
    step();
    check("flush_drop_valid", code_valid, 0);
    check("redir_addr", imem_addr, 8'h20);
    check("redir_req", imem_req, 1);
    step();
    check("redir_wait1_valid", code_valid, 0);
    check("redir_wait1_addr", imem_addr, 8'h20);
    step();
    check("redir_wait2_valid", code_valid, 0);
    step();
    check("redir_valid", code_valid, 1);
    check("redir_code", code, 24'h100020);
    check("redir_pc", code_pc, 8'h20);
    check("redir_next_addr", imem_addr, 8'h21);
    step();
    check("consume_no_return", code_valid, 0);

    // Async reset with a request outstanding, then restart at RESET_PC.
    #2 reset = 1'b1;
    #1 check_reset_outputs("rst_req");
    step();
    reset = 1'b0;
    step();
    check("restart_req", imem_req, 1);
    check("restart_addr", imem_addr, 8'h00);

    // 4-bit address instance: PC wraps 15 -> 0.
    w_reset = 1'b0;
    step();
    check("w_first_req", w_req, 1);
    check("w_first_addr", w_addr, 0);
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("w%0d_valid", i), w_valid, 1);
      check($sformatf("w%0d_pc", i), w_pc, i % 16);
      check($sformatf("w%0d_code", i), w_code, 32'h100000 + (i % 16));
      check($sformatf("w%0d_addr", i), w_addr, (i + 1) % 16);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
